// File: rtl/fft_stage_sequencer_pkg.sv
// fft_stage_sequencer_pkg
//   Definitions shared by the FFT stage sequencer slice: the sequencer
//   state encoding, the default transform size, its stage count and the
//   default butterfly latency.
package fft_stage_sequencer_pkg;

  localparam int unsigned DEFAULT_N          = 1024;
  localparam int unsigned LOG2N              = $clog2(DEFAULT_N);
  localparam int unsigned DEFAULT_BF_LATENCY = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_SWAP  = 3'd3,
    S_DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// fft_stage_sequencer_if
//   Memory-side bundle between the stage sequencer and the ping-pong
//   sample memory / twiddle ROM.
//   bank_sel  ping-pong bank select
//   rd_addr   read address
//   rd_valid  read data valid (one cycle after rd_addr)
//   rd_last   final operand of the stage, qualifies rd_valid
//   tw_addr   twiddle ROM index, aligned with rd_valid
//   wr_en     write enable
//   wr_addr   write address
//   master: driven by the sequencer; slave: observed by the memory side.
interface fft_stage_sequencer_if
  import fft_stage_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = LOG2N
);

  logic                  bank_sel;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_valid;
  logic                  rd_last;
  logic [ADDR_WIDTH-2:0] tw_addr;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;

  modport master (
    output bank_sel, rd_addr, rd_valid, rd_last, tw_addr, wr_en, wr_addr
  );

  modport slave (
    input  bank_sel, rd_addr, rd_valid, rd_last, tw_addr, wr_en, wr_addr
  );

endinterface

// File: rtl/fft_addr_gen.sv
// fft_addr_gen
//   Combinational radix-2 operand address and twiddle index generator.
//   stage_i    stage index 0..ADDR_WIDTH-1
//   k_i        operand counter within the stage (pair b = k>>1, k[0] picks
//              top or bottom operand)
//   rd_addr_o  memory address of operand k
//   tw_addr_o  twiddle ROM index for pair b
module fft_addr_gen
  import fft_stage_sequencer_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH = LOG2N,
  localparam int unsigned SW         = $clog2(ADDR_WIDTH) + 1
) (
  input  logic [SW-1:0]         stage_i,
  input  logic [ADDR_WIDTH-1:0] k_i,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic [ADDR_WIDTH-2:0] tw_addr_o
);

  logic [ADDR_WIDTH-1:0] b;
  logic [ADDR_WIDTH-1:0] h;
  logic [ADDR_WIDTH-1:0] mask;
  logic [ADDR_WIDTH-1:0] top;
  logic [SW-1:0]         tw_shift;

  always_comb begin
    b    = {1'b0, k_i[ADDR_WIDTH-1:1]};
    h    = ADDR_WIDTH'(1) << stage_i;
    mask = h - ADDR_WIDTH'(1);
    // Insert a zero bit at position 'stage' of the pair index to get the
    // top operand; the bottom operand sits h above it.
    top  = ((b >> stage_i) << (stage_i + SW'(1))) | (b & mask);
    rd_addr_o = k_i[0] ? (top + h) : top;
    // The pair offset within its group is below h, so the shifted index
    // always fits in ADDR_WIDTH-1 bits.
    tw_shift  = SW'(ADDR_WIDTH - 1) - stage_i;
    tw_addr_o = (k_i[ADDR_WIDTH-1:1] & mask[ADDR_WIDTH-2:0]) << tw_shift;
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
//   Sequences the LOG2N radix-2 stages of an in-place ping-pong FFT: streams
//   operand addresses to the memory, delays them through the butterfly
//   latency to produce write addresses, and swaps banks between stages.
//   clk    clock, rising edge
//   rst    asynchronous active-low reset
//   start  one-cycle request for a full transform (ignored unless idle)
//   stage  current stage index
//   busy   transform in progress (READ, DRAIN, SWAP)
//   done   one-cycle pulse after the final stage swap
//   mem    memory-side bundle (master modport)
module fft_stage_sequencer
  import fft_stage_sequencer_pkg::*;
#(
  parameter  int unsigned N          = DEFAULT_N,
  parameter  int unsigned ADDR_WIDTH = $clog2(N),
  parameter  int unsigned BF_LATENCY = DEFAULT_BF_LATENCY,
  localparam int unsigned SW         = $clog2(ADDR_WIDTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [SW-1:0]          stage,
  output logic                   busy,
  output logic                   done,
  fft_stage_sequencer_if.master  mem
);

  localparam int unsigned DEPTH      = 1 + BF_LATENCY;
  localparam int unsigned LAST_STAGE = ADDR_WIDTH - 1;
  localparam int unsigned CNT_W      = ADDR_WIDTH + 1;

  seq_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] k_q, k_d;
  logic [SW-1:0]         stage_q, stage_d;
  logic                  bank_q, bank_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;

  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [ADDR_WIDTH-2:0] tw_cur_q;
  logic [ADDR_WIDTH-2:0] tw_addr_q;
  logic                  rd_valid_q;
  logic                  rd_last_q;
  logic                  busy_q;
  logic                  done_q;

  logic [ADDR_WIDTH-1:0] gen_addr;
  logic [ADDR_WIDTH-2:0] gen_tw;

  logic [DEPTH-1:0]      wv_q;
  logic [ADDR_WIDTH-1:0] wa_q [DEPTH];

  logic                  issue;

  // rd_addr_q holds the operand of the current READ cycle.
  assign issue = (state_q == S_READ);

  // Addresses are generated for the next cycle's stage/k so that rd_addr
  // is already valid in the first READ cycle after IDLE or SWAP.
  fft_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .stage_i   (stage_d),
    .k_i       (k_d),
    .rd_addr_o (gen_addr),
    .tw_addr_o (gen_tw)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = '0;
    stage_d  = stage_q;
    bank_d   = bank_q;
    wr_cnt_d = wr_cnt_q + CNT_W'(wv_q[DEPTH-1]);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          stage_d = '0;
        end
      end
      S_READ: begin
        k_d = k_q + ADDR_WIDTH'(1);
        if (k_q == ADDR_WIDTH'(N - 1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave as soon as the final write of the stage is on the bus,
        // so SWAP directly follows the last write cycle.
        if (wr_cnt_d == CNT_W'(N)) begin
          state_d = S_SWAP;
        end
      end
      S_SWAP: begin
        wr_cnt_d = '0;
        bank_d   = ~bank_q;
        if (stage_q < SW'(LAST_STAGE)) begin
          stage_d = stage_q + SW'(1);
          state_d = S_READ;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      stage_q    <= '0;
      bank_q     <= 1'b0;
      wr_cnt_q   <= '0;
      rd_addr_q  <= '0;
      tw_cur_q   <= '0;
      tw_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      stage_q  <= stage_d;
      bank_q   <= bank_d;
      wr_cnt_q <= wr_cnt_d;
      if (state_d == S_READ) begin
        rd_addr_q <= gen_addr;
        tw_cur_q  <= gen_tw;
      end
      // One cycle of memory read latency.
      rd_valid_q <= issue;
      rd_last_q  <= issue && (k_q == ADDR_WIDTH'(N - 1));
      tw_addr_q  <= tw_cur_q;
      busy_q     <= (state_d inside {S_READ, S_DRAIN, S_SWAP});
      done_q     <= (state_d == S_DONE);
    end
  end

  // Write-back pipeline: read address delayed by read latency plus
  // butterfly latency, so results land in read order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wv_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        wa_q[i] <= '0;
      end
    end else begin
      wv_q    <= {wv_q[DEPTH-2:0], issue};
      wa_q[0] <= rd_addr_q;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        wa_q[i] <= wa_q[i-1];
      end
    end
  end

  assign stage        = stage_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign mem.bank_sel = bank_q;
  assign mem.rd_addr  = rd_addr_q;
  assign mem.rd_valid = rd_valid_q;
  assign mem.rd_last  = rd_last_q;
  assign mem.tw_addr  = tw_addr_q;
  assign mem.wr_en    = wv_q[DEPTH-1];
  assign mem.wr_addr  = wa_q[DEPTH-1];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer
//   Bench for fft_stage_sequencer: a small N=8 instance exercised with
//   randomized start timing, spurious starts and a mid-stage reset, and an
//   N=1024 instance run through a full transform. Expected address streams
//   come from a radix-2 group/offset model.
module tb_fft_stage_sequencer;
  import fft_stage_sequencer_pkg::*;

  localparam int unsigned NA  = 8;
  localparam int unsigned AWA = 3;
  localparam int unsigned BFA = 4;
  localparam int unsigned NB  = 1024;
  localparam int unsigned AWB = 10;
  localparam int unsigned STAGE_CYCLES_A = 14;

  logic clk;
  logic rst;
  logic start_a, start_b;
  logic [$clog2(AWA):0] stage_a;
  logic [$clog2(AWB):0] stage_b;
  logic busy_a, done_a, busy_b, done_b;

  fft_stage_sequencer_if #(.ADDR_WIDTH(AWA)) mem_a ();
  fft_stage_sequencer_if #(.ADDR_WIDTH(AWB)) mem_b ();

  fft_stage_sequencer #(.N(NA), .ADDR_WIDTH(AWA), .BF_LATENCY(BFA)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stage(stage_a),
    .busy(busy_a), .done(done_a), .mem(mem_a)
  );

  fft_stage_sequencer #(.N(NB), .ADDR_WIDTH(AWB), .BF_LATENCY(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stage(stage_b),
    .busy(busy_b), .done(done_b), .mem(mem_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: pair p of stage s belongs to group p/h at offset p%h;
  // the group spans 2h words, the offset selects the twiddle.
  function automatic int unsigned model_addr(int unsigned s, int unsigned j);
    int unsigned h   = 1 << s;
    int unsigned p   = j / 2;
    int unsigned top = (p / h) * 2 * h + (p % h);
    return top + (j % 2) * h;
  endfunction

  function automatic int unsigned model_tw(int unsigned n, int unsigned s, int unsigned j);
    int unsigned h = 1 << s;
    return ((j / 2) % h) * (n / (2 * h));
  endfunction

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned addr;
    int unsigned tw;
    int unsigned stg;
    int unsigned bank;
    int unsigned last;
    int unsigned cyc;
  } rd_rec_t;

  typedef struct {
    int unsigned addr;
    int unsigned bank;
    int unsigned cyc;
  } wr_rec_t;

  rd_rec_t rd_qa[$];
  wr_rec_t wr_qa[$];
  int unsigned done_cnt_a = 0;
  int unsigned wr_outside_a = 0;
  logic [AWA-1:0] prev_rd_a = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (mem_a.rd_valid)
        rd_qa.push_back(rd_rec_t'{addr: 32'(prev_rd_a), tw: 32'(mem_a.tw_addr),
                                  stg: 32'(stage_a), bank: 32'(mem_a.bank_sel),
                                  last: 32'(mem_a.rd_last), cyc: cyc - 1});
      if (mem_a.wr_en)
        wr_qa.push_back(wr_rec_t'{addr: 32'(mem_a.wr_addr),
                                  bank: 32'(mem_a.bank_sel), cyc: cyc});
      if (mem_a.wr_en && !busy_a) wr_outside_a <= wr_outside_a + 1;
      if (done_a) done_cnt_a <= done_cnt_a + 1;
    end
    prev_rd_a <= mem_a.rd_addr;
  end

  int unsigned rd_idx_b = 0;
  int unsigned wr_idx_b = 0;
  int unsigned done_cnt_b = 0;
  int unsigned rd_mis_b [AWB];
  int unsigned wr_mis_b [AWB];
  int unsigned wr_per_stage_b [AWB];
  logic [AWB-1:0] prev_rd_b = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (mem_b.rd_valid) begin
        if (rd_idx_b < NB * AWB) begin
          if (32'(prev_rd_b) != model_addr(rd_idx_b / NB, rd_idx_b % NB) ||
              32'(mem_b.tw_addr) != model_tw(NB, rd_idx_b / NB, rd_idx_b % NB) ||
              32'(stage_b) != rd_idx_b / NB ||
              mem_b.rd_last != ((rd_idx_b % NB) == NB - 1))
            rd_mis_b[rd_idx_b / NB] <= rd_mis_b[rd_idx_b / NB] + 1;
        end
        rd_idx_b <= rd_idx_b + 1;
      end
      if (mem_b.wr_en) begin
        if (wr_idx_b < NB * AWB) begin
          if (32'(mem_b.wr_addr) != model_addr(wr_idx_b / NB, wr_idx_b % NB) ||
              32'(mem_b.bank_sel) != (wr_idx_b / NB) % 2)
            wr_mis_b[wr_idx_b / NB] <= wr_mis_b[wr_idx_b / NB] + 1;
        end
        if (32'(stage_b) < AWB)
          wr_per_stage_b[stage_b] <= wr_per_stage_b[stage_b] + 1;
        wr_idx_b <= wr_idx_b + 1;
      end
      if (done_b) done_cnt_b <= done_cnt_b + 1;
    end
    prev_rd_b <= mem_b.rd_addr;
  end

  task automatic clear_a();
    rd_qa.delete();
    wr_qa.delete();
    done_cnt_a   = 0;
    wr_outside_a = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic check_zero_a(input string pfx);
    check_eq({pfx, " stage"},    32'(stage_a), 0);
    check_eq({pfx, " bank_sel"}, 32'(mem_a.bank_sel), 0);
    check_eq({pfx, " rd_addr"},  32'(mem_a.rd_addr), 0);
    check_eq({pfx, " tw_addr"},  32'(mem_a.tw_addr), 0);
    check_eq({pfx, " wr_addr"},  32'(mem_a.wr_addr), 0);
    check_eq({pfx, " ctl"},      32'({mem_a.rd_valid, mem_a.rd_last, mem_a.wr_en, busy_a, done_a}), 0);
  endtask

  // Pulse start, optionally spray extra starts while busy, wait for done.
  task automatic run_a(input int unsigned spray);
    bit seen_done = 0;
    repeat ($urandom_range(1, 5)) @(posedge clk);
    #1;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    for (int i = 0; i < 300 && !seen_done; i++) begin
      @(posedge clk);
      #1;
      if (done_a) seen_done = 1;
      start_a = busy_a && ($urandom_range(0, 99) < spray);
    end
    start_a = 1'b0;
    check_eq("run_a done seen", 32'(seen_done), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic verify_a(input int unsigned bank0);
    int unsigned nr;
    int unsigned nw;
    check_eq("rd count", rd_qa.size(), NA * AWA);
    check_eq("wr count", wr_qa.size(), NA * AWA);
    nr = (rd_qa.size() < NA * AWA) ? rd_qa.size() : NA * AWA;
    nw = (wr_qa.size() < nr) ? wr_qa.size() : nr;
    for (int unsigned i = 0; i < nr; i++) begin
      int unsigned s = i / NA;
      int unsigned j = i % NA;
      check_eq($sformatf("rd_addr s%0d j%0d", s, j), rd_qa[i].addr, model_addr(s, j));
      check_eq($sformatf("tw_addr s%0d j%0d", s, j), rd_qa[i].tw, model_tw(NA, s, j));
      check_eq($sformatf("stage s%0d j%0d", s, j), rd_qa[i].stg, s);
      check_eq($sformatf("rd bank s%0d j%0d", s, j), rd_qa[i].bank, bank0 ^ (s % 2));
      check_eq($sformatf("rd_last s%0d j%0d", s, j), rd_qa[i].last, 32'(j == NA - 1));
    end
    for (int unsigned i = 0; i < nw; i++) begin
      int unsigned s = i / NA;
      check_eq($sformatf("wr_addr %0d", i), wr_qa[i].addr, model_addr(s, i % NA));
      check_eq($sformatf("wr delay %0d", i), wr_qa[i].cyc - rd_qa[i].cyc, 1 + BFA);
      check_eq($sformatf("wr bank %0d", i), wr_qa[i].bank, bank0 ^ (s % 2));
    end
    for (int unsigned s = 1; s < AWA; s++) begin
      if (s * NA < nr)
        check_eq($sformatf("stage len %0d", s), rd_qa[s * NA].cyc - rd_qa[(s - 1) * NA].cyc, STAGE_CYCLES_A);
    end
    check_eq("done pulses", done_cnt_a, 1);
    check_eq("wr outside busy", wr_outside_a, 0);
    check_eq("final bank", 32'(mem_a.bank_sel), bank0 ^ (AWA % 2));
    check_eq("idle busy", 32'(busy_a), 0);
  endtask

  initial begin
    bit found;
    rst = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_a("reset");
    check_eq("reset b ctl", 32'({mem_b.wr_en, mem_b.rd_valid, busy_b, done_b, mem_b.bank_sel}), 0);
    rst = 1'b1;

    clear_a();
    run_a(0);
    verify_a(0);

    for (int r = 0; r < 3; r++) begin
      do_reset();
      clear_a();
      run_a(30);
      verify_a(0);
    end

    // Reset in the middle of stage 1 READ.
    do_reset();
    clear_a();
    @(posedge clk);
    #1;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (stage_a == 1 && mem_a.rd_valid) found = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check_eq("reach stage1 read", 32'(found), 1);
    repeat ($urandom_range(0, 3)) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_zero_a("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    clear_a();
    run_a(10);
    verify_a(0);

    // Full-size transform.
    do_reset();
    rd_idx_b = 0;
    wr_idx_b = 0;
    done_cnt_b = 0;
    for (int unsigned s = 0; s < AWB; s++) begin
      rd_mis_b[s] = 0;
      wr_mis_b[s] = 0;
      wr_per_stage_b[s] = 0;
    end
    @(posedge clk);
    #1;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    found = 0;
    for (int i = 0; i < 20000 && !found; i++) begin
      @(posedge clk);
      #1;
      if (done_b) found = 1;
    end
    check_eq("big done seen", 32'(found), 1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("big reads", rd_idx_b, NB * AWB);
    check_eq("big writes", wr_idx_b, NB * AWB);
    for (int unsigned s = 0; s < AWB; s++) begin
      check_eq($sformatf("big wr_en s%0d", s), wr_per_stage_b[s], NB);
      check_eq($sformatf("big rd errs s%0d", s), rd_mis_b[s], 0);
      check_eq($sformatf("big wr errs s%0d", s), wr_mis_b[s], 0);
    end
    check_eq("big done pulses", done_cnt_b, 1);
    check_eq("big final bank", 32'(mem_b.bank_sel), 0);
    check_eq("big idle busy", 32'(busy_b), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
